// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with configurable width, depth and data-phase wait states.
// Out-of-range, misaligned and oversize accesses get a two-cycle ERROR response.
module ahb_sram_ws #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  localparam int          BYTES    = DATA_W / 8;
  localparam int          LB       = $clog2(BYTES);
  localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] LIMIT    = 33'(MEM_DEPTH * BYTES);
  localparam logic [2:0]  MAX_SIZE = 3'(LB);
  localparam logic [2:0]  WS       = 3'(WAIT_STATES);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic [AW-1:0]     word_reg;
  logic [LB-1:0]     lane_reg;
  logic [2:0]        size_reg;
  logic              write_reg;
  logic              ready_reg;
  logic              resp_reg;

  logic              accept;
  logic              err;
  logic [LB-1:0]     align_mask;
  state_t            launch;
  logic [BYTES-1:0]  strobe;
  logic              commit;
  logic              unused_bits;

  assign unused_bits = HTRANS[0];

  // Decode of the address phase being offered this cycle.
  always_comb begin
    accept     = HSEL & HREADY & HTRANS[1];
    align_mask = '0;
    for (int i = 0; i < LB; i++) align_mask[i] = (HSIZE > 3'(i));
    err = (HSIZE > MAX_SIZE) | (|(HADDR[LB-1:0] & align_mask)) | ({1'b0, HADDR} >= LIMIT);
    if (!accept)              launch = ST_IDLE;
    else if (err)             launch = ST_ERR1;
    else if (WAIT_STATES == 0) launch = ST_DATA;
    else                      launch = ST_WAIT;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      lane_reg  <= '0;
      size_reg  <= '0;
      write_reg <= 1'b0;
      ready_reg <= 1'b1;
      resp_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (cnt_reg == 3'd1) begin
            state_reg <= ST_DATA;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ST_ERR1: begin
          state_reg <= ST_ERR2;
          ready_reg <= 1'b1;
          resp_reg  <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all end with HREADYOUT high, so a new transfer may start.
          state_reg <= launch;
          ready_reg <= (launch != ST_WAIT) && (launch != ST_ERR1);
          resp_reg  <= (launch == ST_ERR1);
          cnt_reg   <= WS;
          if (accept) begin
            word_reg  <= HADDR[LB +: AW];
            lane_reg  <= HADDR[LB-1:0];
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
          end
        end
      endcase
    end
  end

  // Aligned access: a lane belongs to the transfer when it shares the same size-sized block.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_strobe
      assign strobe[gi] = ((LB'(gi) >> size_reg) == (lane_reg >> size_reg));
    end
  endgenerate

  assign commit = (state_reg == ST_DATA) && write_reg;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (strobe[i]) mem[word_reg][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

  assign HRDATA    = (state_reg == ST_DATA && !write_reg) ? mem[word_reg] : '0;
  assign HREADYOUT = ready_reg;
  assign HRESP     = resp_reg;
endmodule
